// File: rtl/gpin_pkg.sv
// rtl/gpin_pkg.sv - shared constants for the gpin_edge_irq input port
package gpin_pkg;

  // Register word offsets; offset 1 is reserved and reads as zero.
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  // Edge polarity selection for the capture logic.
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Zero-extends a value of up to 32 bits onto the 32-bit read bus.
  function automatic logic [31:0] zext32(input logic [31:0] value, input int width);
    logic [31:0] result;
    result = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) begin
        result[i] = value[i];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/gpin_sync_edge.sv
// rtl/gpin_sync_edge.sv - per-vector pin synchroniser, delay flop and edge select
module gpin_sync_edge
  import gpin_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_pins,
  output logic [DATA_WIDTH-1:0] o_sync,
  output logic [DATA_WIDTH-1:0] o_edge
);

  logic [DATA_WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] r_sync_d;
  logic [DATA_WIDTH-1:0] w_s;
  logic [DATA_WIDTH-1:0] w_rise;
  logic [DATA_WIDTH-1:0] w_fall;
  logic [DATA_WIDTH-1:0] w_any;

  // Metastability chain: the last stage is the stable synchronised value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= i_pins;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // One-cycle delayed copy of the synchronised value for edge comparison.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync_d <= '0;
    end else begin
      r_sync_d <= w_s;
    end
  end

  assign w_rise = w_s & ~r_sync_d;
  assign w_fall = ~w_s & r_sync_d;
  assign w_any  = w_s ^ r_sync_d;

  // Pick the edge polarity this instance is built for.
  always_comb begin
    o_edge = w_rise;
    if (EDGE_TYPE == EDGE_FALL) begin
      o_edge = w_fall;
    end else if (EDGE_TYPE == EDGE_ANY) begin
      o_edge = w_any;
    end
  end

  assign o_sync = w_s;

endmodule

// File: rtl/gpin_edge_irq.sv
// rtl/gpin_edge_irq.sv - Avalon-MM GP input with edge capture and masked level irq (option: GPIN_BIT_CLEAR_EN)
module gpin_edge_irq
  import gpin_pkg::*;
#(
  parameter int          DATA_WIDTH     = 8,
  parameter int          SYNC_STAGES    = 2,
  parameter int          EDGE_TYPE      = EDGE_RISE,
  parameter logic [31:0] IRQ_MASK_RESET = 32'h0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [31:0]           readdata,
  output logic                  irq
);

  localparam logic [DATA_WIDTH-1:0] LP_MASK_RST = IRQ_MASK_RESET[DATA_WIDTH-1:0];

  logic [DATA_WIDTH-1:0] r_mask;
  logic [DATA_WIDTH-1:0] r_edgecap;
  logic [DATA_WIDTH-1:0] w_sync;
  logic [DATA_WIDTH-1:0] w_edge;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_clr;
  logic [DATA_WIDTH-1:0] w_edgecap_nxt;
  logic [31:0]           w_rdata;
  logic                  w_wr;
  logic                  w_wr_mask;
  logic                  w_wr_edge;
  logic                  w_unused_wdata;

  gpin_sync_edge #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_sync_edge (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_pins  (in_port),
    .o_sync  (w_sync),
    .o_edge  (w_edge)
  );

  assign w_wr      = chipselect & ~write_n;
  assign w_wr_mask = w_wr & (address == ADDR_MASK);
  assign w_wr_edge = w_wr & (address == ADDR_EDGE);
  assign w_wdata   = writedata[DATA_WIDTH-1:0];

  // Upper writedata bits beyond DATA_WIDTH have no effect.
  assign w_unused_wdata = ^writedata;

`ifdef GPIN_BIT_CLEAR_EN
  // Write-1-to-clear: only bits written as 1 are cleared.
  assign w_clr = w_wr_edge ? w_wdata : '0;
`else
  // Any write to the capture register clears every bit.
  assign w_clr = {DATA_WIDTH{w_wr_edge}};
`endif

  // A new edge in the same cycle as a clear keeps the bit set.
  assign w_edgecap_nxt = (r_edgecap & ~w_clr) | w_edge;

  // Sticky edge capture register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edgecap <= '0;
    end else begin
      r_edgecap <= w_edgecap_nxt;
    end
  end

  // Interrupt mask register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask <= LP_MASK_RST;
    end else if (w_wr_mask) begin
      r_mask <= w_wdata;
    end
  end

  // Read mux; reserved and unmapped offsets return zero.
  always_comb begin
    w_rdata = '0;
    case (address)
      ADDR_DATA: w_rdata = zext32(32'(w_sync), DATA_WIDTH);
      ADDR_MASK: w_rdata = zext32(32'(r_mask), DATA_WIDTH);
      ADDR_EDGE: w_rdata = zext32(32'(r_edgecap), DATA_WIDTH);
      default:   w_rdata = '0;
    endcase
  end

  // Registered read data, updated every cycle independent of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= w_rdata;
    end
  end

  assign irq = |(r_edgecap & r_mask);

endmodule

// File: tb/tb_gpin_edge_irq.sv
// tb/tb_gpin_edge_irq.sv - directed self-checking bench for gpin_edge_irq
module tb_gpin_edge_irq;

  localparam int SYNC = 2;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int n_checks;
  int n_errors;
  logic [31:0] rd;

  gpin_edge_irq #(
    .DATA_WIDTH     (8),
    .SYNC_STAGES    (SYNC),
    .EDGE_TYPE      (0),
    .IRQ_MASK_RESET (32'h0)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
    address    = addr;
    chipselect = 1'b1;
    write_n    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    data       = readdata;
    chipselect = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    address    = addr;
    writedata  = data;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    in_port    = 8'h00;

    // Reset state
    cycles(2);
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_readdata", readdata, 32'h0);
    reset_n = 1'b1;
    cycles(1);
    bus_read(2'd0, rd); check("rd_data_rst", rd, 32'h0);
    bus_read(2'd1, rd); check("rd_rsvd_rst", rd, 32'h0);
    bus_read(2'd2, rd); check("rd_mask_rst", rd, 32'h0);
    bus_read(2'd3, rd); check("rd_edge_rst", rd, 32'h0);
    check("irq_after_rst", {31'h0, irq}, 32'h0);

    // Pin to data read
    in_port = 8'hA5;
    cycles(SYNC + 1);
    bus_read(2'd0, rd); check("rd_data_a5", rd, 32'h000000A5);
    bus_read(2'd3, rd); check("rd_edge_a5", rd, 32'h000000A5);
    check("irq_masked_off", {31'h0, irq}, 32'h0);
    bus_write(2'd3, 32'hFF);
    bus_read(2'd3, rd); check("edge_clr_all", rd, 32'h0);

    // Falling edges are not captured in rising mode
    in_port = 8'h00;
    cycles(4);
    bus_read(2'd3, rd); check("fall_ignored", rd, 32'h0);

    // Mask write, upper writedata bits ignored
    bus_write(2'd2, 32'h000001FF);
    bus_read(2'd2, rd); check("mask_upper_ign", rd, 32'h000000FF);
    bus_write(2'd2, 32'h01);
    bus_read(2'd2, rd); check("mask_01", rd, 32'h00000001);
    bus_write(2'd1, 32'hFFFFFFFF);
    bus_read(2'd1, rd); check("rsvd_wr_ign", rd, 32'h0);

    // Rising edge on bit0: irq latency
    in_port = 8'h01;
    for (int k = 1; k <= SYNC + 1; k++) begin
      cycles(1);
      check($sformatf("irq_lat_%0d", k), {31'h0, irq}, (k == SYNC + 1) ? 32'h1 : 32'h0);
    end
    bus_read(2'd3, rd); check("edge_bit0", rd, 32'h01);
    in_port = 8'h00;
    cycles(4);
    bus_read(2'd3, rd); check("edge_sticky_fall", rd, 32'h01);
    check("irq_sticky", {31'h0, irq}, 32'h1);

    // Clear behaviour with edgecapture = 0x03
    in_port = 8'h02;
    cycles(4);
    bus_read(2'd3, rd); check("edge_03", rd, 32'h03);
    bus_write(2'd3, 32'h01);
    check("irq_after_clr", {31'h0, irq}, 32'h0);
    bus_read(2'd3, rd);
`ifdef GPIN_BIT_CLEAR_EN
    check("clr_w1c", rd, 32'h02);
`else
    check("clr_all", rd, 32'h00);
`endif
    in_port = 8'h00;
    cycles(4);

    // Mask write drops irq the next cycle
    in_port = 8'h01;
    cycles(4);
    in_port = 8'h00;
    cycles(4);
    check("irq_bit0_again", {31'h0, irq}, 32'h1);
    bus_write(2'd2, 32'h00);
    check("irq_mask_off", {31'h0, irq}, 32'h0);
    bus_write(2'd2, 32'h01);
    check("irq_mask_on", {31'h0, irq}, 32'h1);

    // Edge and clear on bit0 in the same cycle: set wins
    in_port = 8'h01;
    cycles(SYNC);
    bus_write(2'd3, 32'hFF);
    check("irq_set_wins", {31'h0, irq}, 32'h1);
    bus_read(2'd3, rd); check("edge_set_wins", rd, 32'h01);
    bus_write(2'd3, 32'hFF);
    bus_read(2'd3, rd); check("edge_clr_after", rd, 32'h0);
    check("irq_clr_after", {31'h0, irq}, 32'h0);

    // Reset mid-operation
    bus_write(2'd2, 32'hFF);
    in_port = 8'h00;
    cycles(4);
    in_port = 8'hFF;
    cycles(4);
    bus_read(2'd3, rd); check("edge_ff", rd, 32'hFF);
    address = 2'd3;
    cycles(1);
    check("irq_ff", {31'h0, irq}, 32'h1);
    reset_n = 1'b0;
    #1;
    check("midrst_irq", {31'h0, irq}, 32'h0);
    check("midrst_readdata", readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    cycles(SYNC + 2);
    bus_read(2'd3, rd); check("post_rst_one_edge", rd, 32'hFF);
    bus_read(2'd2, rd); check("post_rst_mask", rd, 32'h0);
    check("post_rst_irq", {31'h0, irq}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
